// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file write-back control slice.
// Consumed by rf_wb_arbiter_if, rr_arbiter users and rf_wb_arbiter.
package rf_ctrl_pkg;

  localparam int NREQ  = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MDU = 2;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CNT_W = 2;

  // Round-robin pointer width and the saturation value of a scoreboard counter.
  localparam int               PTR_W   = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of write-back request, register-file port, issue and scoreboard signals.
// slave = the arbiter's view, master = the surrounding pipeline / bench.
//
// Handshake: a transfer from requester i happens at a posedge where
// wb_valid[i] & wb_ready[i]; a requester holds valid/addr/data stable until
// that edge, and wb_ready never waits on anything but valid and the pointer.
interface rf_wb_arbiter_if;
  import rf_ctrl_pkg::*;

  logic [NREQ-1:0]    wb_valid;
  logic [NREQ*AW-1:0] wb_addr;
  logic [NREQ*DW-1:0] wb_data;
  logic [NREQ-1:0]    wb_ready;

  logic               rf_we;
  logic [AW-1:0]      rf_a3;
  logic [DW-1:0]      rf_wd;

  logic               iss_valid;
  logic [AW-1:0]      iss_addr;
  logic               iss_ready;

  logic [AW-1:0]      q1_addr;
  logic [AW-1:0]      q2_addr;
  logic               q1_busy;
  logic               q2_busy;
  logic               sb_err;

  // Round-robin pointer, exported for checkers.
  logic [PTR_W-1:0]   dbg_ptr;

  modport slave (
    input  wb_valid, wb_addr, wb_data, iss_valid, iss_addr, q1_addr, q2_addr,
    output wb_ready, rf_we, rf_a3, rf_wd, iss_ready, q1_busy, q2_busy, sb_err, dbg_ptr
  );

  modport master (
    output wb_valid, wb_addr, wb_data, iss_valid, iss_addr, q1_addr, q2_addr,
    input  wb_ready, rf_we, rf_a3, rf_wd, iss_ready, q1_busy, q2_busy, sb_err, dbg_ptr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches valid_i starting at ptr_i and
// returns a one-hot grant plus the pointer to use after that grant.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] ptr_next_o
);

  logic found;

  // First valid at or after ptr_i (wrapping) wins; pointer holds on no grant.
  always_comb begin
    grant_o    = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && valid_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          ptr_next_o = PW'((i + 1) % N);
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and destination scoreboard for the 32x32 register file.
// Optional feature macro: RF_WB_SCOREBOARD_EN builds the per-register
// outstanding-write counters; without it iss_ready=1 and busy/sb_err are 0.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  rf_wb_arbiter_if.slave bus
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [AW-1:0]    g_addr;
  logic [DW-1:0]    g_data;
  logic             rf_we_q;
  logic [AW-1:0]    rf_a3_q;
  logic [DW-1:0]    rf_wd_q;

  rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_rr (
    .valid_i    (bus.wb_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .ptr_next_o (ptr_d)
  );

  assign bus.wb_ready = grant;
  assign bus.dbg_ptr  = ptr_q;
  // The write port never stalls, so any grant is a transfer.
  assign xfer = |grant;

  // Mux the granted requester's address and data.
  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_addr = bus.wb_addr[i*AW +: AW];
        g_data = bus.wb_data[i*DW +: DW];
      end
    end
  end

  // Advance the round-robin pointer past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Register-file port: one cycle after a transfer; $0 writes never assert we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= xfer && (g_addr != '0);
      if (xfer) begin
        rf_a3_q <= g_addr;
        rf_wd_q <= g_data;
      end
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_a3 = rf_a3_q;
  assign bus.rf_wd = rf_wd_q;

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic             inc, dec, err_q;

  assign bus.iss_ready = (bus.iss_addr == '0) || (cnt_q[bus.iss_addr] != CNT_MAX);
  assign inc = bus.iss_valid && bus.iss_ready && (bus.iss_addr != '0);
  assign dec = xfer && (g_addr != '0);

  // Per-register outstanding counts; same-register inc+dec cancels out,
  // and a decrement of an empty counter flags sb_err until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc && (bus.iss_addr == AW'(r)) && !(dec && (g_addr == AW'(r))))
          cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        else if (dec && (g_addr == AW'(r)) && !(inc && (bus.iss_addr == AW'(r)))
                 && (cnt_q[r] != '0))
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
      end
      if (dec && (cnt_q[g_addr] == '0)) err_q <= 1'b1;
    end
  end

  assign bus.q1_busy = (bus.q1_addr != '0) && (cnt_q[bus.q1_addr] != '0);
  assign bus.q2_busy = (bus.q2_addr != '0) && (cnt_q[bus.q2_addr] != '0);
  assign bus.sb_err  = err_q;
`else
  assign bus.iss_ready = 1'b1;
  assign bus.q1_busy   = 1'b0;
  assign bus.q2_busy   = 1'b0;
  assign bus.sb_err    = 1'b0;
`endif

endmodule
